// File: rtl/level_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : level_sequencer
// Purpose  : Game flow sequencer (title, play, blanked room transition,
//            game over, win) that drives the room select and lives count.
// Revision : 1.0
// ============================================================================
module level_sequencer #(
  parameter int BLANK_FRAMES = 60,
  parameter int LIVES_INIT   = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       start_key,
  input  logic       pipe_enter,
  input  logic       flag_reached,
  input  logic       mario_dead,
  output logic [9:0] Sel,
  output logic       blank,
  output logic [2:0] lives,
  output logic       load_room,
  output logic       game_over,
  output logic       game_won
);

  localparam logic [7:0] c_blank_frames = 8'(BLANK_FRAMES);
  localparam logic [2:0] c_lives_init   = 3'(LIVES_INIT);
  localparam logic [2:0] c_room_over    = 3'd1;
  localparam logic [2:0] c_room_under   = 3'd2;
  localparam logic [2:0] c_room_castle  = 3'd3;

  typedef enum logic [2:0] {
    S_TITLE = 3'd0,
    S_PLAY  = 3'd1,
    S_TRANS = 3'd2,
    S_OVER  = 3'd3,
    S_WIN   = 3'd4
  } state_t;

  state_t     r_state;
  logic [2:0] r_room;
  logic [2:0] r_target;
  logic [2:0] r_lives;
  logic [7:0] r_cnt;
  logic [9:0] r_sel;
  logic       r_blank;
  logic       r_load;
  logic       r_over;
  logic       r_won;
  logic       r_start_q;
  logic       r_pipe_q;
  logic       r_flag_q;
  logic       r_dead_q;

  logic       w_ev_start;
  logic       w_ev_pipe;
  logic       w_ev_flag;
  logic       w_ev_dead;
  logic [7:0] w_cnt_inc;
  logic [9:0] w_room_sel;
  logic [9:0] w_target_sel;

  assign w_ev_start   = start_key    & ~r_start_q;
  assign w_ev_pipe    = pipe_enter   & ~r_pipe_q;
  assign w_ev_flag    = flag_reached & ~r_flag_q;
  assign w_ev_dead    = mario_dead   & ~r_dead_q;
  assign w_cnt_inc    = r_cnt + 8'd1;
  assign w_room_sel   = {7'b0, r_room};
  assign w_target_sel = {7'b0, r_target};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      // Edge history resets high so a key held through reset is not an event
      r_start_q <= 1'b1;
      r_pipe_q  <= 1'b1;
      r_flag_q  <= 1'b1;
      r_dead_q  <= 1'b1;
      r_state   <= S_TITLE;
      r_room    <= 3'd0;
      r_target  <= 3'd0;
      r_lives   <= 3'd0;
      r_cnt     <= 8'd0;
      r_sel     <= 10'd0;
      r_blank   <= 1'b0;
      r_load    <= 1'b0;
      r_over    <= 1'b0;
      r_won     <= 1'b0;
    end else begin
      r_start_q <= start_key;
      r_pipe_q  <= pipe_enter;
      r_flag_q  <= flag_reached;
      r_dead_q  <= mario_dead;
      r_load    <= 1'b0;
      case (r_state)
        S_TITLE: begin
          if (w_ev_start) begin
            r_lives  <= c_lives_init;
            r_target <= c_room_over;
            r_state  <= S_TRANS;
            r_cnt    <= 8'd0;
            r_blank  <= 1'b1;
            r_sel    <= w_room_sel;
          end
        end
        S_PLAY: begin
          if (w_ev_dead) begin
            if (r_lives <= 3'd1) begin
              r_lives <= 3'd0;
              r_state <= S_OVER;
              r_over  <= 1'b1;
              r_sel   <= 10'd0;
            end else begin
              r_lives  <= r_lives - 3'd1;
              r_target <= c_room_over;
              r_state  <= S_TRANS;
              r_cnt    <= 8'd0;
              r_blank  <= 1'b1;
            end
          end else if (w_ev_flag) begin
            if (r_room == c_room_castle) begin
              r_state <= S_WIN;
              r_won   <= 1'b1;
              r_sel   <= 10'd0;
            end else begin
              r_target <= c_room_castle;
              r_state  <= S_TRANS;
              r_cnt    <= 8'd0;
              r_blank  <= 1'b1;
            end
          end else if (w_ev_pipe && (r_room == c_room_over || r_room == c_room_under)) begin
            r_target <= (r_room == c_room_over) ? c_room_under : c_room_over;
            r_state  <= S_TRANS;
            r_cnt    <= 8'd0;
            r_blank  <= 1'b1;
          end
        end
        S_TRANS: begin
          if (frame_tick) begin
            if (w_cnt_inc == c_blank_frames) begin
              r_room  <= r_target;
              r_load  <= 1'b1;
              r_state <= S_PLAY;
              r_blank <= 1'b0;
              r_cnt   <= 8'd0;
              r_sel   <= w_target_sel;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        S_OVER, S_WIN: begin
          if (w_ev_start) begin
            r_state <= S_TITLE;
            r_over  <= 1'b0;
            r_won   <= 1'b0;
            r_sel   <= 10'd0;
          end
        end
        default: begin
          r_state <= S_TITLE;
          r_sel   <= 10'd0;
          r_blank <= 1'b0;
          r_over  <= 1'b0;
          r_won   <= 1'b0;
        end
      endcase
    end
  end

  assign Sel       = r_sel;
  assign blank     = r_blank;
  assign lives     = r_lives;
  assign load_room = r_load;
  assign game_over = r_over;
  assign game_won  = r_won;

endmodule
`default_nettype wire

// File: tb/tb_level_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_level_sequencer
// Purpose  : Directed scenarios plus random play against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_level_sequencer;

  localparam int c_bf    = 4;
  localparam int c_lives = 3;

  localparam int MD_TITLE = 0;
  localparam int MD_PLAY  = 1;
  localparam int MD_TRANS = 2;
  localparam int MD_OVER  = 3;
  localparam int MD_WIN   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_key = 1'b0;
  logic       pipe_enter = 1'b0;
  logic       flag_reached = 1'b0;
  logic       mario_dead = 1'b0;
  logic [9:0] sel;
  logic       blank;
  logic [2:0] lives;
  logic       load_room;
  logic       game_over;
  logic       game_won;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_mode, m_room, m_target, m_lives, m_frames_left, m_load;
  bit p_st, p_pp, p_fl, p_dd;

  level_sequencer #(.BLANK_FRAMES(c_bf), .LIVES_INIT(c_lives)) dut (
    .Clk(clk), .Reset(rst), .frame_tick(frame_tick), .start_key(start_key),
    .pipe_enter(pipe_enter), .flag_reached(flag_reached), .mario_dead(mario_dead),
    .Sel(sel), .blank(blank), .lives(lives), .load_room(load_room),
    .game_over(game_over), .game_won(game_won)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic enter_trans(input int tgt);
    m_target      = tgt;
    m_mode        = MD_TRANS;
    m_frames_left = c_bf;
  endtask

  task automatic model_step(input bit r, input bit ft, input bit st,
                            input bit pp, input bit fl, input bit dd);
    bit es, ep, ef, ed;
    if (r) begin
      m_mode = MD_TITLE; m_room = 0; m_target = 0; m_lives = 0;
      m_frames_left = 0; m_load = 0;
      p_st = 1; p_pp = 1; p_fl = 1; p_dd = 1;
      return;
    end
    es = st && !p_st; ep = pp && !p_pp; ef = fl && !p_fl; ed = dd && !p_dd;
    p_st = st; p_pp = pp; p_fl = fl; p_dd = dd;
    m_load = 0;
    case (m_mode)
      MD_TITLE: if (es) begin m_lives = c_lives; enter_trans(1); end
      MD_PLAY: begin
        if (ed) begin
          if (m_lives <= 1) begin m_lives = 0; m_mode = MD_OVER; end
          else begin m_lives = m_lives - 1; enter_trans(1); end
        end else if (ef) begin
          if (m_room == 3) m_mode = MD_WIN;
          else enter_trans(3);
        end else if (ep) begin
          if (m_room == 1) enter_trans(2);
          else if (m_room == 2) enter_trans(1);
        end
      end
      MD_TRANS: if (ft) begin
        m_frames_left = m_frames_left - 1;
        if (m_frames_left == 0) begin
          m_room = m_target; m_load = 1; m_mode = MD_PLAY;
        end
      end
      default: if (es) m_mode = MD_TITLE;
    endcase
  endtask

  task automatic step(input bit r, input bit ft, input bit st,
                      input bit pp, input bit fl, input bit dd);
    int e_sel;
    @(negedge clk);
    rst = r; frame_tick = ft; start_key = st;
    pipe_enter = pp; flag_reached = fl; mario_dead = dd;
    model_step(r, ft, st, pp, fl, dd);
    @(posedge clk);
    #1;
    e_sel = (m_mode == MD_PLAY || m_mode == MD_TRANS) ? m_room : 0;
    check("sel", 32'(sel), 32'(e_sel));
    check("blank", 32'(blank), 32'(m_mode == MD_TRANS));
    check("lives", 32'(lives), 32'(m_lives));
    check("load_room", 32'(load_room), 32'(m_load));
    check("game_over", 32'(game_over), 32'(m_mode == MD_OVER));
    check("game_won", 32'(game_won), 32'(m_mode == MD_WIN));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic trans_done();
    for (int i = 0; i < c_bf; i++) begin
      step(0, 1, 0, 0, 0, 0);
      if (i < c_bf - 1) check("trans_blank_held", 32'(blank), 32'd1);
    end
    check("trans_exit_load", 32'(load_room), 32'd1);
    check("trans_exit_blank", 32'(blank), 32'd0);
  endtask

  initial begin
    // Start key held through reset must not start a game
    repeat (2) step(1, 0, 1, 0, 0, 0);
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_lives", 32'(lives), 32'd0);
    repeat (3) begin
      step(0, 0, 1, 0, 0, 0);
      check("held_start_blank", 32'(blank), 32'd0);
    end
    idle();
    step(0, 0, 1, 0, 0, 0);
    check("start_blank", 32'(blank), 32'd1);
    check("start_lives", 32'(lives), 32'd3);
    idle();
    trans_done();
    check("first_sel", 32'(sel), 32'd1);
    check("first_lives", 32'(lives), 32'd3);
    idle();
    check("load_single", 32'(load_room), 32'd0);

    // Death beats flag in the same cycle
    step(0, 0, 0, 0, 1, 1);
    check("dead_flag_lives", 32'(lives), 32'd2);
    check("dead_flag_blank", 32'(blank), 32'd1);
    idle(); trans_done();
    check("dead_flag_room", 32'(sel), 32'd1);

    step(0, 0, 0, 1, 0, 0); idle(); trans_done();
    check("pipe_to_under", 32'(sel), 32'd2);
    step(0, 0, 0, 1, 0, 0); idle(); trans_done();
    check("pipe_to_over", 32'(sel), 32'd1);
    step(0, 0, 0, 0, 1, 0); idle(); trans_done();
    check("flag_to_castle", 32'(sel), 32'd3);
    step(0, 0, 0, 1, 0, 0);
    check("castle_pipe_blank", 32'(blank), 32'd0);
    check("castle_pipe_sel", 32'(sel), 32'd3);
    idle();
    step(0, 0, 0, 0, 1, 0);
    check("win_flag", 32'(game_won), 32'd1);
    check("win_sel", 32'(sel), 32'd0);
    idle();
    step(0, 0, 1, 0, 0, 0);
    check("win_to_title", 32'(game_won), 32'd0);
    idle();

    // New game, lose every life
    step(0, 0, 1, 0, 0, 0); idle(); trans_done();
    check("restart_lives", 32'(lives), 32'd3);
    repeat (2) begin
      step(0, 0, 0, 0, 1, 1); idle(); trans_done();
    end
    check("last_life", 32'(lives), 32'd1);
    step(0, 0, 0, 0, 1, 1);
    check("over_flag", 32'(game_over), 32'd1);
    check("over_sel", 32'(sel), 32'd0);
    check("over_lives", 32'(lives), 32'd0);
    idle();

    // Reset in the middle of a transition
    step(0, 0, 1, 0, 0, 0); idle();
    step(0, 0, 1, 0, 0, 0); idle();
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    check("abort_blank", 32'(blank), 32'd0);
    check("abort_load", 32'(load_room), 32'd0);
    check("abort_sel", 32'(sel), 32'd0);
    step(0, 1, 0, 0, 0, 0);
    check("abort_no_late_load", 32'(load_room), 32'd0);

    // Random play
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
